// File: rtl/connect4_pkg.sv
// Shared constants, cell codes and state encoding for the
// Connect-4 move scheduler.
package connect4_pkg;

    localparam int ROWS_DEF = 6;
    localparam int COLS_DEF = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OVER
    } sched_state_t;

    // Bit offset of cell (r,c) inside the flat board vector.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return 2 * (r * cols + c);
    endfunction

endpackage

// File: rtl/line_check4.sv
// Combinational four-in-a-row detector for lines starting at one
// anchor cell in the +c, +r, +r+c and +r-c directions.
module line_check4
    import connect4_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic [2*ROWS*COLS-1:0]  board,
    input  logic [$clog2(ROWS)-1:0] row,
    input  logic [$clog2(COLS)-1:0] col,
    output logic [1:0]              owner
);

    function automatic logic [1:0] cell_at(
        input logic [2*ROWS*COLS-1:0] b,
        input int                     r,
        input int                     c
    );
        return b[cell_idx(r, c, COLS) +: 2];
    endfunction

    always_comb begin
        logic [1:0] a;
        logic       same;
        int         r0;
        int         c0;
        int         dr;
        int         dc;
        owner = CELL_EMPTY;
        r0    = int'(row);
        c0    = int'(col);
        a     = cell_at(board, r0, c0);
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            // Lines whose far cell leaves the board are never considered.
            same = (a != CELL_EMPTY) &&
                   (r0 + 3 * dr < ROWS) &&
                   (c0 + 3 * dc >= 0) &&
                   (c0 + 3 * dc < COLS);
            for (int i = 1; i < 4; i++) begin
                if (same && cell_at(board, r0 + i * dr, c0 + i * dc) != a)
                    same = 1'b0;
            end
            if (same)
                owner = a;
        end
    end

endmodule

// File: rtl/connect4_move_scheduler.sv
// Owns the board and column heights, places dropped discs and runs a
// one-anchor-per-cycle win scan after every placement.
module connect4_move_scheduler
    import connect4_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_game,
    input  logic                    drop_valid,
    output logic                    drop_ready,
    input  logic [$clog2(COLS)-1:0] drop_col,
    output logic [2*ROWS*COLS-1:0]  board,
    output logic [1:0]              cur_player,
    output logic                    move_done,
    output logic [1:0]              win,
    output logic                    draw,
    output logic                    illegal,
    output logic                    busy
);

    localparam int N  = ROWS * COLS;
    localparam int KW = $clog2(N);
    localparam int HW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    sched_state_t   state;
    logic [HW-1:0]  height [COLS];
    logic [KW-1:0]  k;
    logic [1:0]     hit;
    logic [1:0]     hit_nx;
    logic [1:0]     owner;
    logic [RW-1:0]  anc_r;
    logic [CW-1:0]  anc_c;
    logic [HW-1:0]  sel_h;
    logic           col_ok;
    logic           full;
    logic           last;

    assign drop_ready = (state == IDLE);
    assign busy       = (state == SCAN);

    always_comb begin
        sel_h = '0;
        full  = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (CW'(i) == drop_col)
                sel_h = height[i];
            if (height[i] != HW'(ROWS))
                full = 1'b0;
        end
        col_ok = (int'(drop_col) < COLS) && (sel_h != HW'(ROWS));
        anc_r  = RW'(int'(k) / COLS);
        anc_c  = CW'(int'(k) % COLS);
        last   = (int'(k) == N - 1);
        hit_nx = (owner != CELL_EMPTY) ? owner : hit;
    end

    line_check4 #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_check (
        .board (board),
        .row   (anc_r),
        .col   (anc_c),
        .owner (owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            board      <= '0;
            cur_player <= CELL_P1;
            k          <= '0;
            hit        <= CELL_EMPTY;
            move_done  <= 1'b0;
            win        <= CELL_EMPTY;
            draw       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < COLS; i++)
                height[i] <= '0;
        end else begin
            move_done <= 1'b0;
            illegal   <= 1'b0;
            if (new_game) begin
                state      <= IDLE;
                board      <= '0;
                cur_player <= CELL_P1;
                k          <= '0;
                hit        <= CELL_EMPTY;
                win        <= CELL_EMPTY;
                draw       <= 1'b0;
                for (int i = 0; i < COLS; i++)
                    height[i] <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (drop_valid) begin
                            if (!col_ok) begin
                                illegal <= 1'b1;
                            end else begin
                                board[cell_idx(int'(sel_h), int'(drop_col), COLS) +: 2]
                                    <= cur_player;
                                for (int i = 0; i < COLS; i++)
                                    if (CW'(i) == drop_col)
                                        height[i] <= sel_h + HW'(1);
                                k     <= '0;
                                hit   <= CELL_EMPTY;
                                state <= SCAN;
                            end
                        end
                    end
                    SCAN: begin
                        hit <= hit_nx;
                        k   <= k + KW'(1);
                        if (last) begin
                            move_done <= 1'b1;
                            if (hit_nx != CELL_EMPTY) begin
                                win   <= hit_nx;
                                state <= OVER;
                            end else if (full) begin
                                draw  <= 1'b1;
                                state <= OVER;
                            end else begin
                                cur_player <= (cur_player == CELL_P1) ? CELL_P2 : CELL_P1;
                                state      <= IDLE;
                            end
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
